// File: rtl/multicycle_maincontrol.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath enable and mux select.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset, forces FETCH
//   op        in   instr[31:26] from the instruction register
//   zero      in   ALU zero flag (only affects pcen, combinationally)
//   memwrite  out  data memory write enable
//   irwrite   out  instruction register load
//   regwrite  out  register file write
//   iord      out  memory address select (0 = PC, 1 = ALUOut)
//   alusrca   out  ALU A select (0 = PC, 1 = register A)
//   alusrcb   out  ALU B select (00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2)
//   pcsrc     out  next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump)
//   regdst    out  destination register (0 = rt, 1 = rd)
//   memtoreg  out  writeback data (0 = ALUOut, 1 = data register)
//   Aluop     out  00 = add, 01 = subtract, 10 = decode funct
//   pcen      out  PC load enable
//   state     out  current state, for debug
module multicycle_maincontrol #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] Aluop,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_r;

  // Moore decode of the control word for a given state; anything not listed is 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE: c.alusrcb = 2'b11;           // precompute branch target
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIWB: c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: next_state_s = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) begin
          next_state_s = MEMADR;
        end else if (op == OP_RTYPE) begin
          next_state_s = RTYPEEX;
        end else if (op == OP_BEQ) begin
          next_state_s = BEQEX;
        end else if (op == OP_ADDI) begin
          next_state_s = ADDIEX;
        end else if (op == OP_J) begin
          next_state_s = JEX;
        end else begin
          next_state_s = FETCH;            // unknown op: skip the instruction
        end
      end
      MEMADR: begin
        if (op == OP_LW) begin
          next_state_s = MEMRD;
        end else if (op == OP_SW) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = FETCH;
        end
      end
      MEMRD:   next_state_s = MEMWB;
      RTYPEEX: next_state_s = RTYPEWB;
      ADDIEX:  next_state_s = ADDIWB;
      default: next_state_s = FETCH;       // terminal states and unused codes
    endcase
  end

  // State and control-word registers; the control word is decoded from the
  // next state so it always matches the state register cycle for cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
      ctrl_r  <= decode_ctrl(FETCH);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s);
    end
  end

  assign memwrite = ctrl_r.memwrite;
  assign irwrite  = ctrl_r.irwrite;
  assign regwrite = ctrl_r.regwrite;
  assign iord     = ctrl_r.iord;
  assign alusrca  = ctrl_r.alusrca;
  assign alusrcb  = ctrl_r.alusrcb;
  assign pcsrc    = ctrl_r.pcsrc;
  assign regdst   = ctrl_r.regdst;
  assign memtoreg = ctrl_r.memtoreg;
  assign Aluop    = ctrl_r.aluop;
  // Branch resolution uses the live zero flag, so pcen reacts in the same cycle.
  assign pcen     = ctrl_r.pcwrite | (ctrl_r.branch & zero);
  assign state    = state_r;

endmodule
